// File: rtl/keen_divider.sv
// Iterative restoring divider: one subtract-and-shift step per clock, RISC-V DIV/REM
// semantics for signed operands, valid/ready handshake on both sides.
module keen_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [XLEN-1:0]  rem_reg, q_reg, divisor_mag_reg;
  logic [XLEN-1:0]  quotient_reg, remainder_reg;
  logic             neg_q_reg, neg_r_reg, out_valid_reg;
  logic [CNT_W-1:0] count_reg;

  logic             accept, div_zero, overflow, dividend_neg, divisor_neg, last_step;
  logic [XLEN-1:0]  dividend_mag, divisor_mag, step_rem, step_q;
  logic [XLEN:0]    shifted, trial;
  logic             trial_ok;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;

  assign accept       = in_valid & in_ready;
  assign div_zero     = (divisor == '0);
  assign overflow     = is_signed & (dividend == MOST_NEG) & (divisor == '1);
  assign dividend_neg = is_signed & dividend[XLEN-1];
  assign divisor_neg  = is_signed & divisor[XLEN-1];
  // The most-negative value negates to itself, which is its correct unsigned magnitude.
  assign dividend_mag = dividend_neg ? -dividend : dividend;
  assign divisor_mag  = divisor_neg ? -divisor : divisor;

  // The partial remainder is kept below |divisor|, so the extra bit only appears
  // in the shifted/trial word; its top bit of trial is the borrow.
  assign shifted   = {rem_reg, q_reg[XLEN-1]};
  assign trial     = shifted - {1'b0, divisor_mag_reg};
  assign trial_ok  = ~trial[XLEN];
  assign step_rem  = trial_ok ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  assign step_q    = {q_reg[XLEN-2:0], trial_ok};
  assign last_step = (count_reg == CNT_W'(1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = (div_zero | overflow) ? DONE : CALC;
      CALC: if (last_step) state_next = DONE;
      DONE: if (out_valid_reg & out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      rem_reg         <= '0;
      q_reg           <= '0;
      divisor_mag_reg <= '0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      neg_q_reg       <= 1'b0;
      neg_r_reg       <= 1'b0;
      out_valid_reg   <= 1'b0;
      count_reg       <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (div_zero) begin
              quotient_reg  <= '1;
              remainder_reg <= dividend;
            end else if (overflow) begin
              quotient_reg  <= dividend;
              remainder_reg <= '0;
            end else begin
              rem_reg         <= '0;
              q_reg           <= dividend_mag;
              divisor_mag_reg <= divisor_mag;
              neg_q_reg       <= dividend_neg ^ divisor_neg;
              neg_r_reg       <= dividend_neg;
              count_reg       <= CNT_W'(XLEN);
            end
          end
        end
        CALC: begin
          rem_reg   <= step_rem;
          q_reg     <= step_q;
          count_reg <= count_reg - CNT_W'(1);
          if (last_step) begin
            quotient_reg  <= neg_q_reg ? -step_q : step_q;
            remainder_reg <= neg_r_reg ? -step_rem : step_rem;
          end
        end
        DONE: begin
          // Raised one cycle after entering DONE, dropped on the handshake edge.
          out_valid_reg <= ~(out_valid_reg & out_ready);
        end
        default: ;
      endcase
    end
  end

endmodule
